// File: rtl/bridge_rr_arbiter_ctrl_if.sv
// Request/grant/response bundle between the bridge masters, the arbiter and the slave.
// The controller uses the master modport; the surrounding bridge (or a bench) uses slave.
interface bridge_rr_arbiter_ctrl_if #(
    parameter int N_MASTER = 4,
    parameter int ID_WIDTH = 4
);
    localparam int IDX_W = $clog2(N_MASTER);

    logic [N_MASTER-1:0] data_req_i;
    logic [N_MASTER-1:0] data_gnt_o;
    logic [IDX_W-1:0]    sel_idx_o;
    logic [N_MASTER-1:0] sel_onehot_o;
    logic                data_req_o;
    logic                data_gnt_i;
    logic                data_r_valid_i;
    logic [ID_WIDTH-1:0] data_r_ID_i;
    logic [N_MASTER-1:0] data_r_valid_o;
    logic                idle_o;
    logic                err_o;

    modport master (
        input  data_req_i, data_gnt_i, data_r_valid_i, data_r_ID_i,
        output data_gnt_o, sel_idx_o, sel_onehot_o, data_req_o, data_r_valid_o, idle_o, err_o
    );

    modport slave (
        output data_req_i, data_gnt_i, data_r_valid_i, data_r_ID_i,
        input  data_gnt_o, sel_idx_o, sel_onehot_o, data_req_o, data_r_valid_o, idle_o, err_o
    );
endinterface

// File: rtl/bridge_rr_arbiter_ctrl.sv
// Round-robin arbiter for an N-master -> 1-slave bridge request channel, with per-master
// outstanding-transaction tracking and one-hot response routing.
module bridge_rr_arbiter_ctrl #(
    parameter int N_MASTER        = 4,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic                      clk,
    input logic                      rst,
    bridge_rr_arbiter_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int IDX_W = $clog2(N_MASTER);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
    logic [CNT_W-1:0] cnt_q [N_MASTER];
    logic [CNT_W-1:0] cnt_d [N_MASTER];
    logic             err_q, err_d;

    logic [N_MASTER-1:0] elig;
    logic [N_MASTER-1:0] win_onehot;
    logic [IDX_W-1:0]    win_idx;
    logic [IDX_W-1:0]    cand;
    logic                has_win;
    logic                lock_drop;
    logic                issue;
    logic                handshake;
    logic                rsp_onehot;
    logic                rsp_ok;
    logic                cnt_all_zero;

    always_comb begin
        elig         = '0;
        cnt_all_zero = 1'b1;
        for (int i = 0; i < N_MASTER; i++) begin
            elig[i] = bus.data_req_i[i] && (cnt_q[i] < CNT_MAX);
            if (cnt_q[i] != '0) begin
                cnt_all_zero = 1'b0;
            end
        end
    end

    // A locked master keeps the channel even if it has since become ineligible.
    always_comb begin
        has_win   = 1'b0;
        win_idx   = '0;
        cand      = '0;
        lock_drop = 1'b0;
        if (state_q == ST_LOCKED) begin
            win_idx   = lock_idx_q;
            has_win   = bus.data_req_i[lock_idx_q];
            lock_drop = ~bus.data_req_i[lock_idx_q];
        end else begin
            for (int off = 0; off < N_MASTER; off++) begin
                cand = IDX_W'((int'(rr_ptr_q) + off) % N_MASTER);
                if (!has_win && elig[cand]) begin
                    has_win = 1'b1;
                    win_idx = cand;
                end
            end
        end
    end

    always_comb begin
        issue      = has_win && !rst;
        handshake  = issue && bus.data_gnt_i;
        win_onehot = issue ? (N_MASTER'(1) << win_idx) : '0;
        rsp_onehot = (bus.data_r_ID_i != '0) &&
                     ((bus.data_r_ID_i & (bus.data_r_ID_i - ID_WIDTH'(1))) == '0);
        rsp_ok     = bus.data_r_valid_i && rsp_onehot;

        bus.data_req_o     = issue;
        bus.data_gnt_o     = win_onehot & {N_MASTER{bus.data_gnt_i}};
        bus.sel_onehot_o   = win_onehot;
        bus.sel_idx_o      = issue ? win_idx : sel_idx_q;
        bus.data_r_valid_o = (bus.data_r_valid_i && !rst) ? bus.data_r_ID_i : '0;
        bus.idle_o         = (state_q == ST_IDLE) && !(|bus.data_req_i) && cnt_all_zero;
        bus.err_o          = err_q;
    end

    // A grant and a response for the same master cancel out in the counter.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        sel_idx_d  = sel_idx_q;
        err_d      = err_q;
        cnt_d      = cnt_q;

        if (issue) begin
            sel_idx_d = win_idx;
            if (bus.data_gnt_i) begin
                rr_ptr_d = IDX_W'((int'(win_idx) + 1) % N_MASTER);
                state_d  = ST_IDLE;
            end else begin
                lock_idx_d = win_idx;
                state_d    = ST_LOCKED;
            end
        end

        if (lock_drop) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
        end

        if (bus.data_r_valid_i && !rsp_onehot) begin
            err_d = 1'b1;
        end

        for (int i = 0; i < N_MASTER; i++) begin
            if (handshake && (win_idx == IDX_W'(i)) && !(rsp_ok && bus.data_r_ID_i[i])) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (rsp_ok && bus.data_r_ID_i[i] && !(handshake && (win_idx == IDX_W'(i)))) begin
                if (cnt_q[i] == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            sel_idx_q  <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < N_MASTER; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            sel_idx_q  <= sel_idx_d;
            err_q      <= err_d;
            for (int i = 0; i < N_MASTER; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
endmodule
